// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encoding and the BCD digit thresholds.
package bcd_to_binary_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
  localparam logic [3:0] BCD_SUB_THRESH = 4'd8;

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Start/busy/done handshake and operand/result bus of the BCD-to-binary converter.
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [BIN_W-1:0]      bin_out;

  modport master (output start, output bcd_in,
                  input  busy,  input  done, input error, input bin_out);
  modport slave  (input  start, input  bcd_in,
                  output busy,  output done, output error, output bin_out);
endinterface

// File: rtl/bcd_to_binary_seq_sub3.sv
// Reverse double-dabble digit cell: undoes the add-3 correction of binary-to-BCD.
module bcd_sub3
  import bcd_to_binary_seq_pkg::*;
(
  input  logic [3:0] nib,
  output logic [3:0] res
);
  assign res = (nib >= BCD_SUB_THRESH) ? nib - 4'd3 : nib;
endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: one right shift plus per-digit subtract-3 per clock,
// with a start/busy/done handshake and invalid-digit detection.
module bcd_to_binary_seq
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
)(
  input  logic              clk,
  input  logic              rst,
  bcd_to_binary_seq_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);

  state_t           state;
  logic [SR_W-1:0]  sreg;
  logic [SR_W-1:0]  sreg_shr;
  logic [SR_W-1:0]  sreg_nxt;
  logic [CNT_W-1:0] count;
  logic             busy_r;
  logic             done_r;
  logic             error_r;
  logic [BIN_W-1:0] bin_r;

  function automatic logic bcd_invalid(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > BCD_MAX_DIGIT) bad = 1'b1;
    return bad;
  endfunction

  assign sreg_shr                = sreg >> 1;
  assign sreg_nxt[BIN_W-1:0]     = sreg_shr[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_sub3
    bcd_sub3 u_sub3 (
      .nib (sreg_shr[BIN_W + 4*g +: 4]),
      .res (sreg_nxt[BIN_W + 4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
      bin_r   <= '0;
      sreg    <= '0;
      count   <= '0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          // An invalid operand enters DONE with the pulse still pending; raise it one cycle later.
          if (state == ST_DONE && !done_r) begin
            done_r <= 1'b1;
          end else if (bus.start) begin
            sreg  <= {bus.bcd_in, {BIN_W{1'b0}}};
            bin_r <= '0;
            if (bcd_invalid(bus.bcd_in)) begin
              error_r <= 1'b1;
              state   <= ST_DONE;
            end else begin
              error_r <= 1'b0;
              count   <= CNT_W'(BIN_W - 1);
              busy_r  <= 1'b1;
              state   <= ST_SHIFT;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          sreg <= sreg_nxt;
          if (count == '0) begin
            bin_r  <= sreg_nxt[BIN_W-1:0];
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= ST_DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.error   = error_r;
  assign bus.bin_out = bin_r;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq: latency, handshake, invalid digits,
// ignored mid-conversion start, reset abort and back-to-back conversions.
module tb_bcd_to_binary_seq;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bcd_to_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] ref_bin(input logic [15:0] b);
    return 14'(b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0]);
  endfunction

  // Single conversion; inj_at / rst_at (busy-cycle index, 0 = off) perturb it mid-flight.
  task automatic conv(input string tag, input logic [15:0] b, input logic [13:0] exp_bin,
                      input logic exp_err, input int inj_at, input int rst_at);
    int lat;
    int nbusy;
    bus.bcd_in = b;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat   = 1;
    nbusy = 0;
    chk({tag, "_clr"}, 32'(bus.bin_out), 32'h0);
    while (!bus.done && lat < 40) begin
      if (bus.busy) nbusy++;
      if (lat == inj_at) begin
        bus.bcd_in = 16'h0042;
        bus.start  = 1'b1;
      end
      if (lat == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({tag, "_rst_busy"}, 32'(bus.busy), 32'h0);
        chk({tag, "_rst_done"}, 32'(bus.done), 32'h0);
        chk({tag, "_rst_bin"}, 32'(bus.bin_out), 32'h0);
        chk({tag, "_rst_err"}, 32'(bus.error), 32'h0);
        return;
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    chk({tag, "_done_seen"}, 32'(bus.done), 32'h1);
    chk({tag, "_latency"}, 32'(lat), exp_err ? 32'd2 : 32'd15);
    chk({tag, "_busy_cycles"}, 32'(nbusy), exp_err ? 32'd0 : 32'd14);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'h0);
    chk({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
    chk({tag, "_err"}, 32'(bus.error), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.done), 32'h0);
    chk({tag, "_hold"}, 32'(bus.bin_out), 32'(exp_bin));
  endtask

  initial begin
    logic [15:0] ops [12];
    int          cyc;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    chk("reset_err", 32'(bus.error), 32'h0);
    chk("reset_bin", 32'(bus.bin_out), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    conv("c9999", 16'h9999, 14'h270F, 1'b0, 0, 0);
    conv("c1234", 16'h1234, 14'h04D2, 1'b0, 0, 0);
    conv("c0000", 16'h0000, 14'h0000, 1'b0, 0, 0);
    conv("c0001", 16'h0001, 14'h0001, 1'b0, 0, 0);
    conv("bad12A4", 16'h12A4, 14'h0000, 1'b1, 0, 0);
    conv("inject", 16'h1234, 14'h04D2, 1'b0, 5, 0);
    conv("abort", 16'h9999, 14'h0000, 1'b0, 0, 7);
    conv("c0512", 16'h0512, 14'h0200, 1'b0, 0, 0);

    ops[0] = 16'h9999;
    ops[1] = 16'h0000;
    for (int i = 2; i < 12; i++)
      ops[i] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};

    bus.bcd_in = ops[0];
    bus.start  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!bus.done && cyc < 40);
      chk("b2b_done_seen", 32'(bus.done), 32'h1);
      chk("b2b_period", 32'(cyc), 32'd15);
      chk("b2b_bin", 32'(bus.bin_out), 32'(ref_bin(ops[k])));
      chk("b2b_err", 32'(bus.error), 32'h0);
      if (k < 11) bus.bcd_in = ops[k+1];
      else        bus.start  = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle_busy", 32'(bus.busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
